// File: rtl/rtc_pkg.sv
// -----------------------------------------------------------------------------
// rtc_pkg -- shared definitions for the BCD real-time clock.
//
// Contents:
//   * digit field offsets for the 24-bit BCD time word
//       {hr10[23:20], hr1[19:16], min10[15:12], min1[11:8], sec10[7:4], sec1[3:0]}
//   * digit/hour limits
//   * BCD helpers: field validation, one-second increment with carry chain,
//     and 12 h <-> 24 h hour conversion (display and alarm paths use these)
// -----------------------------------------------------------------------------
package rtc_pkg;

  localparam int SEC1_LSB  = 0;
  localparam int SEC10_LSB = 4;
  localparam int MIN1_LSB  = 8;
  localparam int MIN10_LSB = 12;
  localparam int HR1_LSB   = 16;
  localparam int HR10_LSB  = 20;

  localparam logic [3:0] SEC10_MAX  = 4'd5;
  localparam logic [3:0] MIN10_MAX  = 4'd5;
  localparam logic [6:0] HOUR_MAX   = 7'd23;
  localparam logic [6:0] HOUR12_MAX = 7'd12;

  // Hour as shown in 12 h mode.
  typedef struct packed {
    logic       pm;
    logic [7:0] hour;  // BCD 01..12
  } hour12_t;

  // Two BCD digits to binary. Only meaningful for digits <= 9.
  function automatic logic [6:0] bcd_to_bin(input logic [7:0] bcd);
    return (7'(bcd[7:4]) * 7'd10) + 7'(bcd[3:0]);
  endfunction

  // Binary 0..29 to two BCD digits.
  function automatic logic [7:0] bin_to_bcd(input logic [4:0] bin);
    logic [3:0] tens;
    logic [3:0] ones;
    if (bin >= 5'd20) begin
      tens = 4'd2;
      ones = 4'(bin - 5'd20);
    end else if (bin >= 5'd10) begin
      tens = 4'd1;
      ones = 4'(bin - 5'd10);
    end else begin
      tens = 4'd0;
      ones = 4'(bin);
    end
    return {tens, ones};
  endfunction

  // Every digit <= 9, tens of seconds/minutes <= 5. Hour range checked separately.
  function automatic logic digits_ok(input logic [23:0] t);
    logic ok;
    ok = 1'b1;
    for (int d = SEC1_LSB; d <= HR10_LSB; d += 4) begin
      if (t[d +: 4] > 4'd9) ok = 1'b0;
    end
    if (t[SEC10_LSB +: 4] > SEC10_MAX) ok = 1'b0;
    if (t[MIN10_LSB +: 4] > MIN10_MAX) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic valid_24h(input logic [23:0] t);
    return digits_ok(t) && (bcd_to_bin(t[HR1_LSB +: 8]) <= HOUR_MAX);
  endfunction

  function automatic logic valid_12h(input logic [23:0] t);
    logic [6:0] h;
    h = bcd_to_bin(t[HR1_LSB +: 8]);
    return digits_ok(t) && (h != 7'd0) && (h <= HOUR12_MAX);
  endfunction

  // 24 h BCD hour -> 12 h BCD hour + PM flag (00 -> 12 AM, 12 -> 12 PM).
  function automatic hour12_t to_12h(input logic [7:0] h24_bcd);
    logic [6:0] h;
    hour12_t    r;
    h    = bcd_to_bin(h24_bcd);
    r.pm = (h >= HOUR12_MAX);
    if (h == 7'd0)             r.hour = 8'h12;
    else if (h > HOUR12_MAX)   r.hour = bin_to_bcd(5'(h - HOUR12_MAX));
    else                       r.hour = h24_bcd;
    return r;
  endfunction

  // 12 h BCD hour (01..12) + PM flag -> 24 h BCD hour.
  function automatic logic [7:0] to_24h(input logic [7:0] h12_bcd, input logic pm);
    logic [6:0] h;
    h = bcd_to_bin(h12_bcd);
    if (h == HOUR12_MAX) return pm ? 8'h12 : 8'h00;
    return pm ? bin_to_bcd(5'(h + HOUR12_MAX)) : h12_bcd;
  endfunction

  // 24 h hour + 1 with 23 -> 00 wrap.
  function automatic logic [7:0] hour_inc(input logic [7:0] h);
    if (bcd_to_bin(h) == HOUR_MAX) return 8'h00;
    if (h[3:0] == 4'd9)            return {h[7:4] + 4'd1, 4'd0};
    return {h[7:4], h[3:0] + 4'd1};
  endfunction

  // One-second advance with the full carry chain resolved in one step.
  function automatic logic [23:0] time_inc(input logic [23:0] t);
    logic [23:0] n;
    n = t;
    if (t[SEC1_LSB +: 4] != 4'd9) begin
      n[SEC1_LSB +: 4] = t[SEC1_LSB +: 4] + 4'd1;
    end else begin
      n[SEC1_LSB +: 4] = 4'd0;
      if (t[SEC10_LSB +: 4] != SEC10_MAX) begin
        n[SEC10_LSB +: 4] = t[SEC10_LSB +: 4] + 4'd1;
      end else begin
        n[SEC10_LSB +: 4] = 4'd0;
        if (t[MIN1_LSB +: 4] != 4'd9) begin
          n[MIN1_LSB +: 4] = t[MIN1_LSB +: 4] + 4'd1;
        end else begin
          n[MIN1_LSB +: 4] = 4'd0;
          if (t[MIN10_LSB +: 4] != MIN10_MAX) begin
            n[MIN10_LSB +: 4] = t[MIN10_LSB +: 4] + 4'd1;
          end else begin
            n[MIN10_LSB +: 4] = 4'd0;
            n[HR1_LSB +: 8]   = hour_inc(t[HR1_LSB +: 8]);
          end
        end
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/rtc_bcd_core_if.sv
// -----------------------------------------------------------------------------
// rtc_bcd_core_if -- control/time bus of the RTC core.
//   master : controller side (drives run/mode/load, reads time)
//   slave  : rtc_bcd_core side
// Signals: run_i, mode_12h_i, load_i, load_time_i[23:0], load_pm_i,
//          time_o[23:0], pm_o, tick_o, load_err_o
// With RTC_ALARM_EN defined, also: alarm_set_i, alarm_time_i[23:0],
//          alarm_clr_i, alarm_o.
// -----------------------------------------------------------------------------
interface rtc_bcd_core_if;
  logic        run_i;
  logic        mode_12h_i;
  logic        load_i;
  logic [23:0] load_time_i;
  logic        load_pm_i;
  logic [23:0] time_o;
  logic        pm_o;
  logic        tick_o;
  logic        load_err_o;
`ifdef RTC_ALARM_EN
  logic        alarm_set_i;
  logic [23:0] alarm_time_i;
  logic        alarm_clr_i;
  logic        alarm_o;

  modport master (
    output run_i, mode_12h_i, load_i, load_time_i, load_pm_i,
    output alarm_set_i, alarm_time_i, alarm_clr_i,
    input  time_o, pm_o, tick_o, load_err_o, alarm_o
  );
  modport slave (
    input  run_i, mode_12h_i, load_i, load_time_i, load_pm_i,
    input  alarm_set_i, alarm_time_i, alarm_clr_i,
    output time_o, pm_o, tick_o, load_err_o, alarm_o
  );
`else
  modport master (
    output run_i, mode_12h_i, load_i, load_time_i, load_pm_i,
    input  time_o, pm_o, tick_o, load_err_o
  );
  modport slave (
    input  run_i, mode_12h_i, load_i, load_time_i, load_pm_i,
    output time_o, pm_o, tick_o, load_err_o
  );
`endif
endinterface

// File: rtl/rtc_prescaler.sv
// -----------------------------------------------------------------------------
// rtc_prescaler -- divide-by-DIV counter producing the one-second wrap strobe.
// Ports:
//   clk_i, rst_ni : clock, async active-low reset
//   run_i         : count enable; counter holds when low
//   clr_i         : synchronous clear to 0 (has priority over counting)
//   wrap_o        : high in the cycle the counter sits at DIV-1 while running;
//                   the counter returns to 0 on that edge
// -----------------------------------------------------------------------------
module rtc_prescaler #(
  parameter  int unsigned DIV     = 10,
  localparam int unsigned PRESC_W = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  input  logic clr_i,
  output logic wrap_o
);

  localparam logic [PRESC_W-1:0] TERMINAL = PRESC_W'(DIV - 1);

  logic [PRESC_W-1:0] cnt_q, cnt_d;

  assign wrap_o = run_i && (cnt_q == TERMINAL);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || wrap_o) cnt_d = '0;
    else if (run_i)      cnt_d = cnt_q + PRESC_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rtc_bcd_core.sv
// -----------------------------------------------------------------------------
// rtc_bcd_core -- BCD real-time clock (hh:mm:ss) with 12/24 h display,
// validated time load, run/stop and tick strobe.
// Parameters: CLK_FREQ_HZ (input clock), TICK_HZ (increment rate; must divide
//             CLK_FREQ_HZ exactly).
// Ports:
//   clk_i, rst_ni : clock, async active-low reset
//   bus (slave)   : run_i, mode_12h_i, load_i, load_time_i, load_pm_i,
//                   time_o, pm_o, tick_o, load_err_o
//                   (+ alarm_set_i, alarm_time_i, alarm_clr_i, alarm_o
//                    when RTC_ALARM_EN is defined)
// Time is stored in 24 h BCD; the 12 h view is purely combinational.
// -----------------------------------------------------------------------------
module rtc_bcd_core
  import rtc_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 10000000,
  parameter int unsigned TICK_HZ     = 1
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  rtc_bcd_core_if.slave  bus
);

  localparam int unsigned DIV = CLK_FREQ_HZ / TICK_HZ;

  logic [23:0] time_q, time_d;
  logic        tick_q, tick_d;
  logic        err_q,  err_d;
  logic        wrap;
  logic        presc_clr;
  logic        load_ok;
  logic        load_take;
  logic [23:0] load_24h;
  logic        alarm_err;
  hour12_t     disp_h;

  rtc_prescaler #(.DIV(DIV)) u_prescaler (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .run_i  (bus.run_i),
    .clr_i  (presc_clr),
    .wrap_o (wrap)
  );

  // Load word normalised to 24 h; in 12 h mode only the hour field changes.
  always_comb begin
    load_24h = bus.load_time_i;
    if (bus.mode_12h_i) load_24h[HR1_LSB +: 8] = to_24h(bus.load_time_i[HR1_LSB +: 8], bus.load_pm_i);
  end

  assign load_ok   = bus.mode_12h_i ? valid_12h(bus.load_time_i) : valid_24h(bus.load_time_i);
  assign load_take = bus.load_i && load_ok;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the branches can leave a value unassigned and infer a latch.
  always_comb begin
    time_d    = time_q;
    tick_d    = 1'b0;
    presc_clr = 1'b0;
    if (load_take) begin
      // An accepted load overrides a coincident wrap: no increment, no tick.
      time_d    = load_24h;
      presc_clr = 1'b1;
    end else if (wrap) begin
      time_d = time_inc(time_q);
      tick_d = 1'b1;
    end
    err_d = (bus.load_i && !load_ok) || alarm_err;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      time_q <= '0;
      tick_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      time_q <= time_d;
      tick_q <= tick_d;
      err_q  <= err_d;
    end
  end

`ifdef RTC_ALARM_EN
  logic [23:0] alarm_time_q;
  logic        armed_q;
  logic        alarm_q;
  logic        alarm_ok;
  logic        alarm_hit;

  assign alarm_ok  = valid_24h(bus.alarm_time_i);
  assign alarm_err = bus.alarm_set_i && !alarm_ok;
  // Only the increment path can fire; a load landing on the alarm time cannot.
  assign alarm_hit = tick_d && armed_q && (time_d == alarm_time_q);

  // NOTE: the alarm time register is reset along with the rest of the state;
  // it is a single word, and armed_q alone would not make its contents safe to
  // compare when reasoning about reset behaviour.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alarm_time_q <= '0;
      armed_q      <= 1'b0;
      alarm_q      <= 1'b0;
    end else begin
      if (bus.alarm_set_i && alarm_ok) begin
        alarm_time_q <= bus.alarm_time_i;
        armed_q      <= 1'b1;
      end
      // Set wins over a coincident clear.
      if (alarm_hit)            alarm_q <= 1'b1;
      else if (bus.alarm_clr_i) alarm_q <= 1'b0;
    end
  end

  assign bus.alarm_o = alarm_q;
`else
  assign alarm_err = 1'b0;
`endif

  // Presentation: 24 h passes the registers through; 12 h rewrites the hour.
  assign disp_h         = to_12h(time_q[HR1_LSB +: 8]);
  assign bus.time_o     = bus.mode_12h_i ? {disp_h.hour, time_q[MIN10_LSB+3:SEC1_LSB]} : time_q;
  assign bus.pm_o       = bus.mode_12h_i && disp_h.pm;
  assign bus.tick_o     = tick_q;
  assign bus.load_err_o = err_q;

endmodule

// File: tb/tb_rtc_bcd_core.sv
// -----------------------------------------------------------------------------
// tb_rtc_bcd_core -- directed self-checking bench for rtc_bcd_core with
// CLK_FREQ_HZ = 10, TICK_HZ = 1 (one tick every 10 clocks).
// Inputs are driven on the falling edge; outputs are sampled there too.
// Alarm scenario is compiled only when RTC_ALARM_EN is defined.
// -----------------------------------------------------------------------------
module tb_rtc_bcd_core;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks     = 0;
  int   failures   = 0;
  int   bad_digits = 0;

  always #5 clk = ~clk;

  rtc_bcd_core_if bus();

  rtc_bcd_core #(.CLK_FREQ_HZ(10), .TICK_HZ(1)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  // Background watch: every displayed digit must stay legal BCD.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 24; d += 4) begin
        if (bus.time_o[d +: 4] > 4'd9) bad_digits++;
      end
      if (bus.time_o[7:4] > 4'd5)   bad_digits++;
      if (bus.time_o[15:12] > 4'd5) bad_digits++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Applies reset with run_i high, releases it on a falling edge.
  task automatic do_reset();
    rst_n           = 1'b0;
    bus.run_i       = 1'b1;
    bus.mode_12h_i  = 1'b0;
    bus.load_i      = 1'b0;
    bus.load_time_i = '0;
    bus.load_pm_i   = 1'b0;
`ifdef RTC_ALARM_EN
    bus.alarm_set_i  = 1'b0;
    bus.alarm_time_i = '0;
    bus.alarm_clr_i  = 1'b0;
`endif
    idle(3);
    rst_n = 1'b1;
  endtask

  // One-cycle load strobe; returns on the falling edge after the load edge.
  task automatic drive_load(input logic [23:0] t, input logic pm);
    bus.load_time_i = t;
    bus.load_pm_i   = pm;
    bus.load_i      = 1'b1;
    @(negedge clk);
    bus.load_i      = 1'b0;
  endtask

  // Cycles until tick_o is seen (bounded); -1 when no tick arrives.
  task automatic wait_tick(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.tick_o) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.run_i = 1'b1;
    bus.mode_12h_i = 1'b0;
    bus.load_i = 1'b0;
    bus.load_time_i = '0;
    bus.load_pm_i = 1'b0;
`ifdef RTC_ALARM_EN
    bus.alarm_set_i = 1'b0;
    bus.alarm_time_i = '0;
    bus.alarm_clr_i = 1'b0;
`endif
    idle(2);
    checks++;
    if (bus.time_o !== 24'h000000 || bus.tick_o !== 1'b0 || bus.load_err_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: time=%h tick=%b err=%b want time=000000 tick=0 err=0",
               bus.time_o, bus.tick_o, bus.load_err_o);
    end
    bus.mode_12h_i = 1'b1;
    #1;
    checks++;
    if (bus.time_o !== 24'h120000 || bus.pm_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_12h_view: time=%h pm=%b want 120000 pm=0", bus.time_o, bus.pm_o);
    end
    bus.mode_12h_i = 1'b0;
    idle(1);
    rst_n = 1'b1;
  endtask

  task automatic test_first_tick();
    int n;
    wait_tick(n);
    checks++;
    if (n !== 10) begin
      failures++;
      $display("FAIL first_tick_latency: got %0d cycles want 10", n);
    end
    checks++;
    if (bus.time_o !== 24'h000001) begin
      failures++;
      $display("FAIL first_tick_time: got %h want 000001", bus.time_o);
    end
    wait_tick(n);
    checks++;
    if (n !== 10 || bus.time_o !== 24'h000002) begin
      failures++;
      $display("FAIL second_tick: period=%0d time=%h want 10 / 000002", n, bus.time_o);
    end
  endtask

  task automatic test_wrap_24h();
    int n;
    drive_load(24'h235958, 1'b0);
    checks++;
    if (bus.time_o !== 24'h235958 || bus.tick_o !== 1'b0) begin
      failures++;
      $display("FAIL wrap_load: time=%h tick=%b want 235958 tick=0", bus.time_o, bus.tick_o);
    end
    wait_tick(n);
    checks++;
    if (n !== 10 || bus.time_o !== 24'h235959) begin
      failures++;
      $display("FAIL wrap_step1: period=%0d time=%h want 10 / 235959", n, bus.time_o);
    end
    wait_tick(n);
    checks++;
    if (n !== 10 || bus.time_o !== 24'h000000 || bus.pm_o !== 1'b0) begin
      failures++;
      $display("FAIL wrap_midnight: period=%0d time=%h pm=%b want 10 / 000000 pm=0",
               n, bus.time_o, bus.pm_o);
    end
  endtask

  task automatic test_12h();
    int n;
    bus.mode_12h_i = 1'b1;
    drive_load(24'h115959, 1'b0);
    checks++;
    if (bus.time_o !== 24'h115959 || bus.pm_o !== 1'b0) begin
      failures++;
      $display("FAIL h12_load_am: time=%h pm=%b want 115959 pm=0", bus.time_o, bus.pm_o);
    end
    wait_tick(n);
    checks++;
    if (bus.time_o !== 24'h120000 || bus.pm_o !== 1'b1) begin
      failures++;
      $display("FAIL h12_noon: time=%h pm=%b want 120000 pm=1", bus.time_o, bus.pm_o);
    end
    drive_load(24'h125959, 1'b1);
    wait_tick(n);
    checks++;
    if (bus.time_o !== 24'h010000 || bus.pm_o !== 1'b1) begin
      failures++;
      $display("FAIL h12_one_pm: time=%h pm=%b want 010000 pm=1", bus.time_o, bus.pm_o);
    end
    bus.mode_12h_i = 1'b0;
    #1;
    checks++;
    if (bus.time_o !== 24'h130000 || bus.pm_o !== 1'b0) begin
      failures++;
      $display("FAIL h12_back_to_24h: time=%h pm=%b want 130000 pm=0", bus.time_o, bus.pm_o);
    end
  endtask

  task automatic test_load_err();
    logic [23:0] bad [4];
    int n;
    int c;
    bad[0] = 24'h240000;
    bad[1] = 24'h006000;
    bad[2] = 24'h00000A;
    bad[3] = 24'h000000;  // only illegal in 12 h mode
    drive_load(24'h101010, 1'b0);
    c = 0;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      checks++;
      if (bus.load_err_o !== 1'b0) begin
        failures++;
        $display("FAIL load_err_idle[%0d]: err=%b want 0", i, bus.load_err_o);
      end
      if (i == 3) bus.mode_12h_i = 1'b1;
      drive_load(bad[i], 1'b0);
      c += 2;
      checks++;
      if (bus.load_err_o !== 1'b1 || bus.time_o !== 24'h101010 || bus.tick_o !== 1'b0) begin
        failures++;
        $display("FAIL load_err_reject[%0d] %h: err=%b time=%h tick=%b want err=1 time=101010 tick=0",
                 i, bad[i], bus.load_err_o, bus.time_o, bus.tick_o);
      end
    end
    bus.mode_12h_i = 1'b0;
    wait_tick(n);
    checks++;
    if (n !== 10 - c || bus.time_o !== 24'h101011) begin
      failures++;
      $display("FAIL load_err_presc_kept: remaining=%0d time=%h want %0d / 101011",
               n, bus.time_o, 10 - c);
    end
  endtask

  task automatic test_load_on_wrap();
    int n;
    drive_load(24'h000000, 1'b0);
    idle(9);                       // prescaler now at its terminal count
    drive_load(24'h123456, 1'b0);
    checks++;
    if (bus.time_o !== 24'h123456 || bus.tick_o !== 1'b0) begin
      failures++;
      $display("FAIL load_on_wrap: time=%h tick=%b want 123456 tick=0", bus.time_o, bus.tick_o);
    end
    wait_tick(n);
    checks++;
    if (n !== 10 || bus.time_o !== 24'h123457) begin
      failures++;
      $display("FAIL load_on_wrap_next: period=%0d time=%h want 10 / 123457", n, bus.time_o);
    end
  endtask

  task automatic test_run_stop();
    int n;
    int ticks_seen;
    idle(4);
    bus.run_i  = 1'b0;
    ticks_seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.tick_o) ticks_seen++;
    end
    checks++;
    if (ticks_seen !== 0 || bus.time_o !== 24'h123457) begin
      failures++;
      $display("FAIL run_stop_frozen: ticks=%0d time=%h want 0 / 123457", ticks_seen, bus.time_o);
    end
    bus.run_i = 1'b1;
    wait_tick(n);
    checks++;
    if (n !== 6 || bus.time_o !== 24'h123458) begin
      failures++;
      $display("FAIL run_resume: remaining=%0d time=%h want 6 / 123458", n, bus.time_o);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    idle(3);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.time_o !== 24'h000000 || bus.tick_o !== 1'b0 || bus.load_err_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_async: time=%h tick=%b err=%b want 000000/0/0",
               bus.time_o, bus.tick_o, bus.load_err_o);
    end
    idle(2);
    rst_n = 1'b1;
    wait_tick(n);
    checks++;
    if (n !== 10 || bus.time_o !== 24'h000001) begin
      failures++;
      $display("FAIL reset_mid_restart: period=%0d time=%h want 10 / 000001", n, bus.time_o);
    end
  endtask

`ifdef RTC_ALARM_EN
  task automatic test_alarm();
    int n;
    do_reset();
    bus.alarm_time_i = 24'h000005;
    bus.alarm_set_i  = 1'b1;
    @(negedge clk);
    bus.alarm_time_i = 24'h006000;
    @(negedge clk);                // invalid alarm value
    bus.alarm_set_i  = 1'b0;
    checks++;
    if (bus.load_err_o !== 1'b1 || bus.alarm_o !== 1'b0) begin
      failures++;
      $display("FAIL alarm_bad_set: err=%b alarm=%b want 1/0", bus.load_err_o, bus.alarm_o);
    end
    for (int t = 1; t <= 5; t++) begin
      wait_tick(n);
      checks++;
      if (bus.time_o !== 24'(t) || bus.alarm_o !== (t == 5)) begin
        failures++;
        $display("FAIL alarm_tick%0d: time=%h alarm=%b want %h / %b",
                 t, bus.time_o, bus.alarm_o, 24'(t), (t == 5));
      end
    end
    idle(3);
    bus.alarm_clr_i = 1'b1;
    @(negedge clk);
    bus.alarm_clr_i = 1'b0;
    checks++;
    if (bus.alarm_o !== 1'b0) begin
      failures++;
      $display("FAIL alarm_clear: alarm=%b want 0", bus.alarm_o);
    end
  endtask
`endif

  task automatic test_bcd_digits();
    checks++;
    if (bad_digits !== 0) begin
      failures++;
      $display("FAIL bcd_digits: illegal digit samples=%0d want 0", bad_digits);
    end
  endtask

  initial begin
    test_reset();
    test_first_tick();
    test_wrap_24h();
    test_12h();
    test_load_err();
    test_load_on_wrap();
    test_run_stop();
    test_reset_mid();
`ifdef RTC_ALARM_EN
    test_alarm();
`endif
    test_bcd_digits();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
